// File: rtl/mem_resp_pkg.sv
// Shared types and funct3 decode for the data-memory responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Byte-lane mask of an access at offset 0; shifted left by the offset to place it.
  function automatic logic [7:0] size_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 8'h01;
      2'b01:   return 8'h03;
      2'b10:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/lane_align.sv
// Combinational byte-lane logic: load extract/extend, store merge, misalign detect.
module lane_align
  import mem_resp_pkg::*;
(
  input  logic [63:0] i_word,
  input  logic [63:0] i_wdata,
  input  logic [2:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [63:0] o_rdata,
  output logic [63:0] o_wword,
  output logic        o_misalign
);

  logic [1:0]  w_sz;
  logic [63:0] w_lane;
  logic [63:0] w_wdata_sh;
  logic [7:0]  w_bytemask;
  logic [63:0] w_bitmask;

  assign w_sz = i_funct3[1:0];

  // Offset bits below the access size must be zero: none for B, bit0 for H, [1:0] for W, [2:0] for D.
  assign o_misalign = |(i_offset & {&w_sz, w_sz[1], |w_sz});

  assign w_lane     = i_word >> {i_offset, 3'b000};
  assign w_wdata_sh = i_wdata << {i_offset, 3'b000};
  assign w_bytemask = size_mask(i_funct3) << i_offset;

  always_comb begin
    w_bitmask = '0;
    for (int b = 0; b < 8; b++) begin
      w_bitmask[b*8 +: 8] = {8{w_bytemask[b]}};
    end
  end

  assign o_wword = (i_word & ~w_bitmask) | (w_wdata_sh & w_bitmask);

  always_comb begin
    o_rdata = '0;
    case (i_funct3)
      F3_B:    o_rdata = 64'($signed(w_lane[7:0]));
      F3_H:    o_rdata = 64'($signed(w_lane[15:0]));
      F3_W:    o_rdata = 64'($signed(w_lane[31:0]));
      F3_D:    o_rdata = w_lane;
      F3_BU:   o_rdata = {56'd0, w_lane[7:0]};
      F3_HU:   o_rdata = {48'd0, w_lane[15:0]};
      F3_WU:   o_rdata = {32'd0, w_lane[31:0]};
      default: o_rdata = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: 64-bit-word RAM behind a valid/ready request port with
// programmable access latency and byte-lane load/store handling.
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int          IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [60:0] DEPTH_L = 61'(DEPTH_WORDS);
  localparam logic [3:0]  LAT_L   = 4'(LATENCY);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [63:0] r_resp_rdata;

  logic        r_we;
  logic [2:0]  r_funct3;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [63:0] r_mem [DEPTH_WORDS];

  logic             w_accept;
  logic             w_in_range;
  logic             w_misalign;
  logic             w_err;
  logic             w_wr_en;
  logic [IDX_W-1:0] w_idx;
  logic [63:0]      w_word;
  logic [63:0]      w_ld_data;
  logic [63:0]      w_st_word;

  assign w_accept   = req_valid & r_req_ready;
  assign w_idx      = r_addr[3 +: IDX_W];
  // Any set bit above the index field lands here as an out-of-range word index.
  assign w_in_range = (r_addr[63:3] < DEPTH_L);
  assign w_word     = w_in_range ? r_mem[w_idx] : '0;

  lane_align u_lane_align (
    .i_word     (w_word),
    .i_wdata    (r_wdata),
    .i_offset   (r_addr[2:0]),
    .i_funct3   (r_funct3),
    .o_rdata    (w_ld_data),
    .o_wword    (w_st_word),
    .o_misalign (w_misalign)
  );

  assign w_err = w_misalign | ~w_in_range
               | (~r_we & (r_funct3 == 3'b111))
               | (r_we & r_funct3[2]);

  assign w_wr_en = (r_state == ACCESS) & r_we & ~w_err;

  // Request capture: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we     <= req_we;
      r_funct3 <= req_funct3;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
    end
  end

  // Array write at the end of the ACCESS cycle; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_idx] <= w_st_word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cnt       <= LAT_L;
            r_req_ready <= 1'b0;
            r_state     <= (LATENCY > 0) ? WAIT : ACCESS;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          r_resp_err   <= w_err;
          r_resp_rdata <= (w_err | r_we) ? '0 : w_ld_data;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: LATENCY=2 instance (index 0) and LATENCY=0 instance (index 1).
module tb_data_mem_responder;
  import mem_resp_pkg::*;

  logic clk = 1'b0;
  logic reset;

  logic [1:0]       req_valid;
  logic [1:0]       req_we;
  logic [1:0][2:0]  req_funct3;
  logic [1:0][63:0] req_addr;
  logic [1:0][63:0] req_wdata;
  logic [1:0]       resp_ready;
  wire  [1:0]       req_ready;
  wire  [1:0]       resp_valid;
  wire  [1:0]       resp_err;
  wire  [63:0]      resp_rdata0;
  wire  [63:0]      resp_rdata1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vt[$];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid[0]),
    .req_ready  (req_ready[0]),
    .req_we     (req_we[0]),
    .req_funct3 (req_funct3[0]),
    .req_addr   (req_addr[0]),
    .req_wdata  (req_wdata[0]),
    .resp_valid (resp_valid[0]),
    .resp_ready (resp_ready[0]),
    .resp_rdata (resp_rdata0),
    .resp_err   (resp_err[0])
  );

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid[1]),
    .req_ready  (req_ready[1]),
    .req_we     (req_we[1]),
    .req_funct3 (req_funct3[1]),
    .req_addr   (req_addr[1]),
    .req_wdata  (req_wdata[1]),
    .resp_valid (resp_valid[1]),
    .resp_ready (resp_ready[1]),
    .resp_rdata (resp_rdata1),
    .resp_err   (resp_err[1])
  );

  function automatic logic [63:0] rdata_of(input int s);
    return (s == 0) ? resp_rdata0 : resp_rdata1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addv(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                      input logic [63:0] wdata, input logic [63:0] er, input logic ee);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.exp_rdata = er; v.exp_err = ee;
    vt.push_back(v);
  endtask

  task automatic drive(input int s, input logic we, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wdata);
    req_we[s]     = we;
    req_funct3[s] = f3;
    req_addr[s]   = addr;
    req_wdata[s]  = wdata;
    req_valid[s]  = 1'b1;
  endtask

  // Drive a request, push its expected response, and return just after the accept edge.
  task automatic send(input int s, input logic we, input logic [2:0] f3, input logic [63:0] addr,
                      input logic [63:0] wdata, input logic [63:0] er, input logic ee);
    exp_t e;
    int t;
    e.rdata = er;
    e.err   = ee;
    sbq.push_back(e);
    drive(s, we, f3, addr, wdata);
    t = 0;
    while (!req_ready[s] && t < 64) begin
      tick();
      t++;
    end
    if (!req_ready[s]) chk("accept_timeout", 64'(req_ready[s]), 64'd1);
    tick();
    req_valid[s] = 1'b0;
  endtask

  task automatic wait_valid(input int s, output int lat);
    lat = 0;
    while (!resp_valid[s] && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  task automatic pop_cmp(input int s, input string nm);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({nm, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sbq.pop_front();
      chk({nm, "_rdata"}, rdata_of(s), e.rdata);
      chk({nm, "_err"}, 64'(resp_err[s]), 64'(e.err));
    end
  endtask

  task automatic get_resp(input int s, input string nm);
    int lat;
    wait_valid(s, lat);
    chk({nm, "_lat"}, 64'(lat), (s == 0) ? 64'd3 : 64'd1);
    pop_cmp(s, nm);
    resp_ready[s] = 1'b1;
    tick();
    resp_ready[s] = 1'b0;
    chk({nm, "_idle_rdy"}, 64'(req_ready[s]), 64'd1);
    chk({nm, "_idle_vld"}, 64'(resp_valid[s]), 64'd0);
  endtask

  task automatic chk_reset(input int s, input string nm);
    chk({nm, "_req_ready"}, 64'(req_ready[s]), 64'd1);
    chk({nm, "_resp_valid"}, 64'(resp_valid[s]), 64'd0);
    chk({nm, "_resp_rdata"}, rdata_of(s), 64'd0);
    chk({nm, "_resp_err"}, 64'(resp_err[s]), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int lat;
    reset      = 1'b1;
    req_valid  = '0;
    req_we     = '0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = '0;
    tick();
    tick();
    chk_reset(0, "rst_l2");
    chk_reset(1, "rst_l0");
    reset = 1'b0;
    tick();

    addv(1, F3_D,   64'h10, 64'h1122334455667788, 64'h0, 0);
    addv(0, F3_D,   64'h10, 64'h0, 64'h1122334455667788, 0);
    addv(0, F3_B,   64'h10, 64'h0, 64'hFFFFFFFFFFFFFF88, 0);
    addv(0, F3_BU,  64'h10, 64'h0, 64'h88, 0);
    addv(0, F3_H,   64'h16, 64'h0, 64'h1122, 0);
    addv(0, F3_W,   64'h14, 64'h0, 64'h11223344, 0);
    addv(0, F3_WU,  64'h14, 64'h0, 64'h11223344, 0);
    addv(1, F3_B,   64'h13, 64'hFFFFFFFFFFFFFFAB, 64'h0, 0);
    addv(0, F3_D,   64'h10, 64'h0, 64'h11223344AB667788, 0);
    addv(1, F3_H,   64'h11, 64'hBEEF, 64'h0, 1);
    addv(0, F3_D,   64'h10, 64'h0, 64'h11223344AB667788, 0);
    addv(0, F3_D,   64'h800, 64'h0, 64'h0, 1);
    addv(1, 3'b100, 64'h10, 64'hDEAD, 64'h0, 1);
    addv(0, F3_D,   64'h10, 64'h0, 64'h11223344AB667788, 0);
    addv(0, 3'b111, 64'h10, 64'h0, 64'h0, 1);
    addv(1, 3'b111, 64'h10, 64'h0, 64'h0, 1);
    addv(0, F3_H,   64'h12, 64'h0, 64'hFFFFFFFFFFFFAB66, 0);
    addv(0, F3_HU,  64'h12, 64'h0, 64'hAB66, 0);
    addv(0, F3_W,   64'h10, 64'h0, 64'hFFFFFFFFAB667788, 0);
    addv(0, F3_WU,  64'h10, 64'h0, 64'hAB667788, 0);
    addv(0, F3_B,   64'h17, 64'h0, 64'h11, 0);
    addv(0, F3_W,   64'h12, 64'h0, 64'h0, 1);
    addv(1, F3_D,   64'h18, 64'h0123456789ABCDEF, 64'h0, 0);
    addv(1, F3_W,   64'h1C, 64'h55555555CAFEF00D, 64'h0, 0);
    addv(0, F3_D,   64'h18, 64'h0, 64'hCAFEF00D89ABCDEF, 0);
    addv(1, F3_H,   64'h1A, 64'h12348001, 64'h0, 0);
    addv(0, F3_H,   64'h1A, 64'h0, 64'hFFFFFFFFFFFF8001, 0);
    addv(0, F3_D,   64'h18, 64'h0, 64'hCAFEF00D8001CDEF, 0);
    addv(1, F3_D,   64'h14, 64'h1, 64'h0, 1);
    addv(1, F3_D,   64'h7F8, 64'hA5A5A5A5A5A5A5A5, 64'h0, 0);
    addv(0, F3_D,   64'h7F8, 64'h0, 64'hA5A5A5A5A5A5A5A5, 0);
    addv(0, F3_D,   64'h8000000000000010, 64'h0, 64'h0, 1);

    foreach (vt[i]) begin
      send(0, vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, vt[i].exp_rdata, vt[i].exp_err);
      get_resp(0, $sformatf("v%0d", i));
    end

    // Response back-pressure with a competing request held on req_valid.
    send(0, 0, F3_D, 64'h10, 64'h0, 64'h11223344AB667788, 0);
    wait_valid(0, lat);
    chk("hold_lat", 64'(lat), 64'd3);
    pop_cmp(0, "hold_first");
    drive(0, 0, F3_D, 64'h18, 64'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("hold%0d_vld", k), 64'(resp_valid[0]), 64'd1);
      chk($sformatf("hold%0d_rdata", k), resp_rdata0, 64'h11223344AB667788);
      chk($sformatf("hold%0d_rdy", k), 64'(req_ready[0]), 64'd0);
    end
    resp_ready[0] = 1'b1;
    tick();
    resp_ready[0] = 1'b0;
    chk("hold_release_rdy", 64'(req_ready[0]), 64'd1);
    chk("hold_release_vld", 64'(resp_valid[0]), 64'd0);
    begin
      exp_t e;
      e.rdata = 64'hCAFEF00D8001CDEF;
      e.err   = 1'b0;
      sbq.push_back(e);
    end
    tick();
    chk("held_accepted", 64'(req_ready[0]), 64'd0);
    req_valid[0] = 1'b0;
    get_resp(0, "held");

    // Reset during WAIT drops an in-flight store.
    send(0, 1, F3_D, 64'h20, 64'h5A5A, 64'h0, 0);
    get_resp(0, "r2_sd");
    send(0, 0, F3_D, 64'h20, 64'h0, 64'h5A5A, 0);
    get_resp(0, "r2_ld");
    drive(0, 1, F3_D, 64'h20, 64'hFFFF);
    tick();
    req_valid[0] = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1 chk_reset(0, "r2_mid");
    #1 reset = 1'b0;
    tick();
    send(0, 0, F3_D, 64'h20, 64'h0, 64'h5A5A, 0);
    get_resp(0, "r2_after");

    // Same sequence on the zero-latency instance; reset lands in ACCESS.
    send(1, 1, F3_D, 64'h20, 64'h5A5A, 64'h0, 0);
    get_resp(1, "r0_sd");
    send(1, 0, F3_D, 64'h20, 64'h0, 64'h5A5A, 0);
    get_resp(1, "r0_ld");
    send(1, 0, F3_BU, 64'h21, 64'h0, 64'h5A, 0);
    get_resp(1, "r0_lbu");
    drive(1, 1, F3_D, 64'h20, 64'hFFFF);
    tick();
    req_valid[1] = 1'b0;
    #2 reset = 1'b1;
    #1 chk_reset(1, "r0_mid");
    #1 reset = 1'b0;
    tick();
    send(1, 0, F3_D, 64'h20, 64'h0, 64'h5A5A, 0);
    get_resp(1, "r0_after");
    send(1, 1, F3_H, 64'h23, 64'h1, 64'h0, 1);
    get_resp(1, "r0_mis");

    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
